// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared control-bundle layout and stall FSM encodings
package pipeline_pkg;

    localparam int CTRL_W        = 8;

    // Control bundle bit positions
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_ALUOP_HI = 3;
    localparam int CTRL_ALUOP_LO = 0;

    // Stall FSM state encodings
    localparam logic RUN   = 1'b0;
    localparam logic STALL = 1'b1;

    // Control value carried by a bubble
    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}};

endpackage

// File: rtl/stall_fsm.sv
// rtl/stall_fsm.sv - load-use stall sequencer producing the hold request
module stall_fsm #(
    parameter int STALL_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_use_hazard,
    input  logic branch_flush,
    output logic hold
);
    import pipeline_pkg::*;

    localparam int CW = (STALL_CYCLES < 1) ? 1 : $clog2(STALL_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(STALL_CYCLES - 1);
    localparam logic          MULTI    = (STALL_CYCLES > 1);

    logic          state;
    logic          state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // State and remaining-stall counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: a flush always wins; STALL ignores new hazards until it counts out
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (branch_flush) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else begin
            case (state)
                RUN: begin
                    if (load_use_hazard) begin
                        cnt_nxt   = CNT_LOAD;
                        state_nxt = MULTI ? STALL : RUN;
                    end
                end
                STALL: begin
                    cnt_nxt = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Hold output: first stall cycle comes straight from the hazard, later ones from STALL
    always_comb begin
        hold = 1'b0;
        if (!rst && !branch_flush) begin
            hold = ((state == RUN) && load_use_hazard) || (state == STALL);
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hold and branch flush
module id_ex_stage #(
    parameter int XLEN         = 32,
    parameter int CTRL_W       = 8,
    parameter int STALL_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              load_use_hazard,
    input  logic              branch_flush,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_reg_write,
    output logic              ex_is_load,
    output logic              exmem_bubble,
    output logic              pc_stall,
    output logic              ifid_stall
);
    import pipeline_pkg::CTRL_REGWRITE;
    import pipeline_pkg::CTRL_MEMREAD;

    logic hold;

    stall_fsm #(
        .STALL_CYCLES (STALL_CYCLES)
    ) u_stall_fsm (
        .clk             (clk),
        .rst             (rst),
        .load_use_hazard (load_use_hazard),
        .branch_flush    (branch_flush),
        .hold            (hold)
    );

    assign pc_stall     = hold;
    assign ifid_stall   = hold;
    assign exmem_bubble = hold;

    // ID/EX register: reset and flush insert a bubble, hold freezes, otherwise capture ID
    always_ff @(posedge clk) begin
        if (rst || branch_flush) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_ctrl     <= '0;
        end else if (!hold) begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            // An empty ID slot must not present a stale RegWrite/MemRead downstream
            ex_ctrl     <= id_valid ? id_ctrl : {CTRL_W{1'b0}};
        end
    end

    assign ex_reg_write = ex_ctrl[CTRL_REGWRITE] & ex_valid;
    assign ex_is_load   = ex_ctrl[CTRL_MEMREAD] & ex_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage with one- and three-cycle stalls
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Input set A drives the STALL_CYCLES=1 instance, set B the STALL_CYCLES=3 instance
    logic        a_valid, b_valid;
    logic [31:0] a_pc, b_pc, a_rs1_data, b_rs1_data, a_rs2_data, b_rs2_data, a_imm, b_imm;
    logic [4:0]  a_rs1, b_rs1, a_rs2, b_rs2, a_rd, b_rd;
    logic [7:0]  a_ctrl, b_ctrl;
    logic        a_haz, b_haz, a_fl, b_fl;

    logic        ao_valid, bo_valid, ao_rw, bo_rw, ao_ld, bo_ld;
    logic [31:0] ao_pc, bo_pc, ao_imm, bo_imm, ao_d1, bo_d1, ao_d2, bo_d2;
    logic [4:0]  ao_rs1, bo_rs1, ao_rs2, bo_rs2, ao_rd, bo_rd;
    logic [7:0]  ao_ctrl, bo_ctrl;
    logic        ao_bub, bo_bub, ao_pcs, bo_pcs, ao_ifs, bo_ifs;

    id_ex_stage #(.XLEN(32), .CTRL_W(8), .STALL_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .id_valid(a_valid), .id_pc(a_pc), .id_rs1(a_rs1), .id_rs2(a_rs2),
        .id_rd(a_rd), .id_rs1_data(a_rs1_data), .id_rs2_data(a_rs2_data), .id_imm(a_imm),
        .id_ctrl(a_ctrl), .load_use_hazard(a_haz), .branch_flush(a_fl),
        .ex_valid(ao_valid), .ex_pc(ao_pc), .ex_imm(ao_imm), .ex_rs1(ao_rs1), .ex_rs2(ao_rs2),
        .ex_rd(ao_rd), .ex_rs1_data(ao_d1), .ex_rs2_data(ao_d2), .ex_ctrl(ao_ctrl),
        .ex_reg_write(ao_rw), .ex_is_load(ao_ld), .exmem_bubble(ao_bub), .pc_stall(ao_pcs),
        .ifid_stall(ao_ifs)
    );

    id_ex_stage #(.XLEN(32), .CTRL_W(8), .STALL_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .id_valid(b_valid), .id_pc(b_pc), .id_rs1(b_rs1), .id_rs2(b_rs2),
        .id_rd(b_rd), .id_rs1_data(b_rs1_data), .id_rs2_data(b_rs2_data), .id_imm(b_imm),
        .id_ctrl(b_ctrl), .load_use_hazard(b_haz), .branch_flush(b_fl),
        .ex_valid(bo_valid), .ex_pc(bo_pc), .ex_imm(bo_imm), .ex_rs1(bo_rs1), .ex_rs2(bo_rs2),
        .ex_rd(bo_rd), .ex_rs1_data(bo_d1), .ex_rs2_data(bo_d2), .ex_ctrl(bo_ctrl),
        .ex_reg_write(bo_rw), .ex_is_load(bo_ld), .exmem_bubble(bo_bub), .pc_stall(bo_pcs),
        .ifid_stall(bo_ifs)
    );

    typedef struct {
        int          d;
        bit          v, rw, ld, bub, st;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step_no = 0;

    task automatic chk(input string nm, input int sn, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", nm, sn, act, exp);
        end
    endtask

    // Operands are derived from pc/rd so every captured field has a distinct known value
    task automatic step(input int d, input bit r, input bit v, input logic [31:0] pc,
                        input logic [4:0] rd, input logic [7:0] ctrl, input bit haz, input bit fl,
                        input bit ev, input logic [31:0] epc, input logic [4:0] erd,
                        input logic [7:0] ectrl, input bit erw, input bit eld, input bit ebub,
                        input bit est);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        {a_valid, a_pc, a_rd, a_rs1, a_rs2, a_rs1_data, a_rs2_data, a_imm, a_ctrl, a_haz, a_fl} = '0;
        {b_valid, b_pc, b_rd, b_rs1, b_rs2, b_rs1_data, b_rs2_data, b_imm, b_ctrl, b_haz, b_fl} = '0;
        if (d == 0) begin
            a_valid = v; a_pc = pc; a_rd = rd; a_rs1 = rd + 5'd1; a_rs2 = rd + 5'd2;
            a_rs1_data = pc ^ 32'hA5A5_0000; a_rs2_data = pc + 32'd1; a_imm = pc + 32'd2;
            a_ctrl = ctrl; a_haz = haz; a_fl = fl;
        end else begin
            b_valid = v; b_pc = pc; b_rd = rd; b_rs1 = rd + 5'd1; b_rs2 = rd + 5'd2;
            b_rs1_data = pc ^ 32'hA5A5_0000; b_rs2_data = pc + 32'd1; b_imm = pc + 32'd2;
            b_ctrl = ctrl; b_haz = haz; b_fl = fl;
        end
        e.d = d; e.v = ev; e.pc = epc; e.rd = erd; e.ctrl = ectrl;
        e.rw = erw; e.ld = eld; e.bub = ebub; e.st = est;
        q.push_back(e);
    endtask

    // Monitor: each negedge pops the expectation for the current cycle and compares
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [31:0] d1, d2, im;
            logic [4:0]  r1, r2;
            e = q.pop_front();
            step_no++;
            d1 = e.bub ? 32'd0 : (e.pc ^ 32'hA5A5_0000);
            d2 = e.bub ? 32'd0 : (e.pc + 32'd1);
            im = e.bub ? 32'd0 : (e.pc + 32'd2);
            r1 = e.bub ? 5'd0 : (e.rd + 5'd1);
            r2 = e.bub ? 5'd0 : (e.rd + 5'd2);
            if (e.d == 0) begin
                chk("ex_valid", step_no, 32'(ao_valid), 32'(e.v));
                chk("ex_pc", step_no, ao_pc, e.pc);
                chk("ex_rd", step_no, 32'(ao_rd), 32'(e.rd));
                chk("ex_ctrl", step_no, 32'(ao_ctrl), 32'(e.ctrl));
                chk("ex_reg_write", step_no, 32'(ao_rw), 32'(e.rw));
                chk("ex_is_load", step_no, 32'(ao_ld), 32'(e.ld));
                chk("ex_rs1", step_no, 32'(ao_rs1), 32'(r1));
                chk("ex_rs2", step_no, 32'(ao_rs2), 32'(r2));
                chk("ex_rs1_data", step_no, ao_d1, d1);
                chk("ex_rs2_data", step_no, ao_d2, d2);
                chk("ex_imm", step_no, ao_imm, im);
                chk("pc_stall", step_no, 32'(ao_pcs), 32'(e.st));
                chk("ifid_stall", step_no, 32'(ao_ifs), 32'(e.st));
                chk("exmem_bubble", step_no, 32'(ao_bub), 32'(e.st));
            end else begin
                chk("ex_valid", step_no, 32'(bo_valid), 32'(e.v));
                chk("ex_pc", step_no, bo_pc, e.pc);
                chk("ex_rd", step_no, 32'(bo_rd), 32'(e.rd));
                chk("ex_ctrl", step_no, 32'(bo_ctrl), 32'(e.ctrl));
                chk("ex_reg_write", step_no, 32'(bo_rw), 32'(e.rw));
                chk("ex_is_load", step_no, 32'(bo_ld), 32'(e.ld));
                chk("ex_rs1", step_no, 32'(bo_rs1), 32'(r1));
                chk("ex_rs2", step_no, 32'(bo_rs2), 32'(r2));
                chk("ex_rs1_data", step_no, bo_d1, d1);
                chk("ex_rs2_data", step_no, bo_d2, d2);
                chk("ex_imm", step_no, bo_imm, im);
                chk("pc_stall", step_no, 32'(bo_pcs), 32'(e.st));
                chk("ifid_stall", step_no, 32'(bo_ifs), 32'(e.st));
                chk("exmem_bubble", step_no, 32'(bo_bub), 32'(e.st));
            end
        end
    end

    initial begin
        int t;
        {a_valid, a_pc, a_rd, a_rs1, a_rs2, a_rs1_data, a_rs2_data, a_imm, a_ctrl, a_haz, a_fl} = '0;
        {b_valid, b_pc, b_rd, b_rs1, b_rs2, b_rs1_data, b_rs2_data, b_imm, b_ctrl, b_haz, b_fl} = '0;

        //    d r v  pc        rd     ctrl   hz fl | ev epc       erd    ectrl  rw ld bub st
        // STALL_CYCLES=1 instance: reset, pass-through, single stall, x0, invalid ctrl, hazard+flush
        step(0, 1, 1, 32'h10, 5'd1,  8'h80, 0, 0,   0, 32'h00, 5'd0,  8'h00, 0, 0, 1, 0);
        step(0, 1, 1, 32'h10, 5'd1,  8'h80, 1, 0,   0, 32'h00, 5'd0,  8'h00, 0, 0, 1, 0);
        step(0, 0, 1, 32'h40, 5'd5,  8'h80, 0, 0,   0, 32'h00, 5'd0,  8'h00, 0, 0, 1, 0);
        step(0, 0, 1, 32'h44, 5'd6,  8'hC0, 0, 0,   1, 32'h40, 5'd5,  8'h80, 1, 0, 0, 0);
        step(0, 0, 1, 32'h48, 5'd7,  8'h80, 1, 0,   1, 32'h44, 5'd6,  8'hC0, 1, 1, 0, 1);
        step(0, 0, 1, 32'h48, 5'd7,  8'h80, 0, 0,   1, 32'h44, 5'd6,  8'hC0, 1, 1, 0, 0);
        step(0, 0, 1, 32'h4C, 5'd0,  8'h80, 0, 0,   1, 32'h48, 5'd7,  8'h80, 1, 0, 0, 0);
        step(0, 0, 0, 32'h50, 5'd8,  8'hFF, 0, 0,   1, 32'h4C, 5'd0,  8'h80, 1, 0, 0, 0);
        step(0, 0, 1, 32'h54, 5'd9,  8'h80, 1, 1,   0, 32'h50, 5'd8,  8'h00, 0, 0, 0, 0);
        step(0, 0, 1, 32'h58, 5'd10, 8'h40, 0, 0,   0, 32'h00, 5'd0,  8'h00, 0, 0, 1, 0);
        step(0, 0, 1, 32'h5C, 5'd11, 8'h80, 0, 0,   1, 32'h58, 5'd10, 8'h40, 0, 1, 0, 0);

        // STALL_CYCLES=3 instance: three-cycle stall, hazard ignored in STALL, re-stall, flush mid-stall
        step(1, 0, 1, 32'h100, 5'd3, 8'hC0, 0, 0,   0, 32'h000, 5'd0, 8'h00, 0, 0, 1, 0);
        step(1, 0, 1, 32'h104, 5'd4, 8'h80, 0, 0,   1, 32'h100, 5'd3, 8'hC0, 1, 1, 0, 0);
        step(1, 0, 1, 32'h108, 5'd5, 8'h80, 1, 0,   1, 32'h104, 5'd4, 8'h80, 1, 0, 0, 1);
        step(1, 0, 1, 32'h108, 5'd5, 8'h80, 0, 0,   1, 32'h104, 5'd4, 8'h80, 1, 0, 0, 1);
        step(1, 0, 1, 32'h108, 5'd5, 8'h80, 1, 0,   1, 32'h104, 5'd4, 8'h80, 1, 0, 0, 1);
        step(1, 0, 1, 32'h108, 5'd5, 8'h80, 0, 0,   1, 32'h104, 5'd4, 8'h80, 1, 0, 0, 0);
        step(1, 0, 1, 32'h10C, 5'd6, 8'h80, 1, 0,   1, 32'h108, 5'd5, 8'h80, 1, 0, 0, 1);
        step(1, 0, 1, 32'h10C, 5'd6, 8'h80, 0, 0,   1, 32'h108, 5'd5, 8'h80, 1, 0, 0, 1);
        step(1, 0, 1, 32'h10C, 5'd6, 8'h80, 0, 1,   1, 32'h108, 5'd5, 8'h80, 1, 0, 0, 0);
        step(1, 0, 1, 32'h110, 5'd7, 8'h80, 0, 0,   0, 32'h000, 5'd0, 8'h00, 0, 0, 1, 0);
        step(1, 0, 1, 32'h114, 5'd8, 8'h80, 0, 0,   1, 32'h110, 5'd7, 8'h80, 1, 0, 0, 0);

        t = 0;
        while (q.size() > 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
